// File: rtl/pulse_train_pkg.sv
// rtl/pulse_train_pkg.sv - shared state encoding and default widths for the pulse-train generator
package pulse_train_pkg;

  localparam int CW_DEF = 8;
  localparam int PW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_train_chan.sv
// rtl/pulse_train_chan.sv - one pulse-train channel: capture registers, phase timer, remaining counter
module pulse_train_chan
  import pulse_train_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          abort,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [CW-1:0] ld_cnt,
  input  logic [PW-1:0] ld_hi,
  input  logic [PW-1:0] ld_lo,
  output logic          pout,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [CW-1:0] rem;
  logic [PW-1:0] tmr;
  logic [PW-1:0] hi_r;
  logic [PW-1:0] lo_r;
  logic          pend;
  logic          accept;

  // pend marks a load taken while en=0; it blocks further loads until the train starts
  assign ld_ready = (state == ST_IDLE) & ~pend & ~abort;
  assign busy     = (state != ST_IDLE);
  assign accept   = ld_valid & ld_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rem   <= '0;
      tmr   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      pend  <= 1'b0;
      pout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        pout  <= 1'b0;
        pend  <= 1'b0;
        tmr   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              hi_r <= ld_hi;
              lo_r <= ld_lo;
              rem  <= ld_cnt;
            end
            if (accept && en) begin
              if (ld_cnt != '0) begin
                state <= ST_HIGH;
                pout  <= 1'b1;
                tmr   <= '0;
              end else begin
                done <= 1'b1;
              end
            end else if (accept) begin
              pend <= 1'b1;
            end else if (pend && en) begin
              pend <= 1'b0;
              if (rem != '0) begin
                state <= ST_HIGH;
                pout  <= 1'b1;
                tmr   <= '0;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_HIGH: begin
            if (en) begin
              if (tmr == hi_r) begin
                tmr  <= '0;
                pout <= 1'b0;
                if (rem == CW'(1)) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
                end else begin
                  state <= ST_LOW;
                  rem   <= rem - 1'b1;
                end
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
          end
          ST_LOW: begin
            if (en) begin
              if (tmr == lo_r) begin
                state <= ST_HIGH;
                pout  <= 1'b1;
                tmr   <= '0;
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            pout  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - NCH-channel pulse-train generator; PULSE_TRAIN_ABORT_EN adds the abort port
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = CW_DEF,
  parameter int PW  = PW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic [NCH-1:0]    abort,
`endif
  input  logic [NCH-1:0]    ld_valid,
  output logic [NCH-1:0]    ld_ready,
  input  logic [NCH*CW-1:0] ld_cnt,
  input  logic [NCH*PW-1:0] ld_hi,
  input  logic [NCH*PW-1:0] ld_lo,
  output logic [NCH-1:0]    pout,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done
);

  logic [NCH-1:0] ch_abort;

`ifdef PULSE_TRAIN_ABORT_EN
  assign ch_abort = abort;
`else
  assign ch_abort = '0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pulse_train_chan #(
      .CW(CW),
      .PW(PW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .abort    (ch_abort[i]),
      .ld_valid (ld_valid[i]),
      .ld_ready (ld_ready[i]),
      .ld_cnt   (ld_cnt[i*CW +: CW]),
      .ld_hi    (ld_hi[i*PW +: PW]),
      .ld_lo    (ld_lo[i*PW +: PW]),
      .pout     (pout[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - scoreboard bench for pulse_train_gen; abort cases under PULSE_TRAIN_ABORT_EN
module tb_pulse_train_gen;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [NCH-1:0]    ld_valid = '0;
  logic [NCH-1:0]    ld_ready;
  logic [NCH*CW-1:0] ld_cnt = '0;
  logic [NCH*PW-1:0] ld_hi = '0;
  logic [NCH*PW-1:0] ld_lo = '0;
  logic [NCH-1:0]    pout;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
`ifdef PULSE_TRAIN_ABORT_EN
  logic [NCH-1:0]    abort = '0;
`endif

  pulse_train_gen #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
`ifdef PULSE_TRAIN_ABORT_EN
    .abort    (abort),
`endif
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_cnt   (ld_cnt),
    .ld_hi    (ld_hi),
    .ld_lo    (ld_lo),
    .pout     (pout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int hi;
    int lo;
    int acc;
    bit lat;
  } exp_t;

  exp_t exp_q[NCH][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   hi_run[NCH];
  int   lo_run[NCH];
  int   pulses[NCH];
  int   bad[NCH];
  int   first_cyc[NCH];
  bit   prev[NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int ch, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0d expected %0d", name, ch, act, exp);
    end
  endtask

  task automatic clr_mon(input int c);
    hi_run[c] = 0;
    lo_run[c] = 0;
    pulses[c] = 0;
    bad[c] = 0;
    first_cyc[c] = 0;
  endtask

  // Monitor: measures each train at the falling edge and pops the scoreboard on done
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      exp_t e;
      bit   p;
      bit   skip;
      skip = 1'b0;
      if (!rst_n) begin
        clr_mon(c);
        exp_q[c].delete();
        prev[c] = 1'b0;
        skip = 1'b1;
      end
`ifdef PULSE_TRAIN_ABORT_EN
      if (!skip && abort[c]) begin
        clr_mon(c);
        exp_q[c].delete();
        prev[c] = 1'b0;
        skip = 1'b1;
      end
`endif
      if (!skip) begin
        p = pout[c];
        if (p && !prev[c]) begin
          if (exp_q[c].size() == 0) begin
            chk("pulse_without_load", c, 1, 0);
          end else if (pulses[c] == 0) begin
            first_cyc[c] = cyc;
          end else if (lo_run[c] != exp_q[c][0].lo + 1) begin
            bad[c]++;
          end
          pulses[c]++;
          lo_run[c] = 0;
        end
        if (!p && prev[c]) begin
          if (exp_q[c].size() > 0 && hi_run[c] != exp_q[c][0].hi + 1) bad[c]++;
          hi_run[c] = 0;
        end
        if (p && en) hi_run[c]++;
        if (!p && busy[c] && en) lo_run[c]++;
        if (done[c]) begin
          if (exp_q[c].size() == 0) begin
            chk("unexpected_done", c, 1, 0);
          end else begin
            e = exp_q[c].pop_front();
            chk("pulse_count", c, pulses[c], e.cnt);
            chk("phase_len_errs", c, bad[c], 0);
            if (e.cnt > 0) chk("done_on_fall", c, int'(prev[c] && !p), 1);
            if (e.lat) chk("latency", c, (e.cnt > 0) ? first_cyc[c] : cyc, e.acc);
            clr_mon(c);
          end
        end
        prev[c] = p;
      end
    end
  end

  task automatic set_ch(input int c, input int n, input int h, input int l);
    ld_cnt[c*CW +: CW] = CW'(n);
    ld_hi[c*PW +: PW]  = PW'(h);
    ld_lo[c*PW +: PW]  = PW'(l);
  endtask

  // Called 1ns after a rising edge; presents the load for exactly one edge
  task automatic fire(input logic [NCH-1:0] mask);
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        chk("ld_ready_before_load", c, int'(ld_ready[c]), 1);
        e.cnt = int'(ld_cnt[c*CW +: CW]);
        e.hi  = int'(ld_hi[c*PW +: PW]);
        e.lo  = int'(ld_lo[c*PW +: PW]);
        e.acc = cyc + 1;
        e.lat = en;
        exp_q[c].push_back(e);
      end
    end
    ld_valid = mask;
    @(posedge clk);
    #1;
    ld_valid = '0;
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int c = 0; c < NCH; c++) s += exp_q[c].size();
    return s;
  endfunction

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while ((busy != '0 || pending() != 0) && k < maxc) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_timeout", -1, int'(k >= maxc), 0);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      clr_mon(c);
      prev[c] = 1'b0;
    end
    #2;
    chk("reset_pout", -1, int'(pout), 0);
    chk("reset_busy", -1, int'(busy), 0);
    chk("reset_done", -1, int'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    chk("ld_ready_after_reset", -1, int'(ld_ready), 15);

    // fastest train: 1,0,1,0,1
    set_ch(0, 3, 0, 0);
    fire(4'b0001);
    chk("first_cycle_high", 0, int'(pout[0]), 1);
    wait_idle(50);

    // 3 high, 2 low, 3 high
    set_ch(0, 2, 2, 1);
    fire(4'b0001);
    wait_idle(50);

    // zero count: done next cycle, no pulse
    set_ch(0, 0, 5, 5);
    fire(4'b0001);
    chk("zero_cnt_ready", 0, int'(ld_ready[0]), 1);
    chk("zero_cnt_busy", 0, int'(busy[0]), 0);
    wait_idle(20);

    // freeze mid-pulse for 4 cycles
    set_ch(1, 3, 3, 3);
    fire(4'b0010);
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("frozen_pout", 1, int'(pout[1]), 1);
      chk("frozen_busy", 1, int'(busy[1]), 1);
    end
    en = 1'b1;
    wait_idle(100);

    // load while disabled: held pending until en returns
    en = 1'b0;
    set_ch(2, 2, 0, 0);
    fire(4'b0100);
    repeat (2) @(posedge clk);
    #1;
    chk("pending_no_busy", 2, int'(busy[2]), 0);
    chk("pending_no_ready", 2, int'(ld_ready[2]), 0);
    en = 1'b1;
    wait_idle(50);

    // all channels at once
    set_ch(0, 1, 1, 0);
    set_ch(1, 5, 0, 2);
    set_ch(2, 255, 0, 0);
    set_ch(3, 7, 2, 1);
    fire(4'b1111);
    wait_idle(2000);

    // back-to-back: reload in the done cycle
    set_ch(3, 2, 0, 0);
    fire(4'b1000);
    begin
      int k;
      k = 0;
      while (!done[3] && k < 50) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("b2b_done_timeout", 3, int'(k >= 50), 0);
    end
    set_ch(3, 1, 1, 0);
    fire(4'b1000);
    wait_idle(50);

    // async reset mid-train
    set_ch(0, 4, 3, 0);
    fire(4'b0001);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pout", 0, int'(pout[0]), 0);
    chk("async_rst_busy", 0, int'(busy[0]), 0);
    chk("async_rst_done", 0, int'(done[0]), 0);
    #10;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ready_after_rst", -1, int'(ld_ready), 15);
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("no_done_after_rst", -1, int'(done), 0);
    end

`ifdef PULSE_TRAIN_ABORT_EN
    // abort during the second pulse of a 4-pulse train
    set_ch(2, 4, 1, 1);
    fire(4'b0100);
    repeat (4) @(posedge clk);
    #1;
    chk("second_pulse_high", 2, int'(pout[2]), 1);
    abort[2] = 1'b1;
    @(posedge clk);
    #1;
    abort[2] = 1'b0;
    chk("abort_pout", 2, int'(pout[2]), 0);
    chk("abort_busy", 2, int'(busy[2]), 0);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", 2, int'(done[2]), 0);
    end

    // abort beats a simultaneous load
    set_ch(3, 2, 0, 0);
    abort[3] = 1'b1;
    ld_valid[3] = 1'b1;
    #1;
    chk("abort_blocks_ready", 3, int'(ld_ready[3]), 0);
    @(posedge clk);
    #1;
    ld_valid[3] = 1'b0;
    abort[3] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_load_dropped", 3, int'(busy[3]) + int'(pout[3]), 0);
    end
`endif

    chk("scoreboard_empty", -1, pending(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
